key_bus_responder: RTL and testbench

KEY_BUS_RESPONDER -- requirements
Module: key_bus_responder

---
 rtl/key_bus_responder.sv | 143 ++++++++++++++
 tb/tb_key_bus_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_bus_responder.sv
// Memory-mapped key FIFO with a status register, a character output port and a
// key-pending interrupt with a re-arm holdoff.
module key_bus_responder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [63:0] KEY_ADDR   = 64'h8000_0010,
  parameter logic [63:0] ART_ADDR   = 64'h8000_0000,
  parameter logic [63:0] STAT_ADDR  = 64'h8000_0018,
  parameter int unsigned HOLDOFF    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  output logic        key_ready,
  input  logic [63:0] bus_address,
  input  logic [63:0] bus_write_data,
  input  logic        bus_write_enable,
  input  logic        bus_read_enable,
  output logic [63:0] bus_read_data,
  output logic [3:0]  interrupt_vector,
  input  logic        interrupt_done,
  output logic [7:0]  char_out,
  output logic        char_valid
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int HCW = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_HOLDOFF} irq_state_t;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  head, tail;
  logic [CW-1:0]  count;
  logic           overflow;
  logic           empty, full, push, pop;
  logic           art_write, stat_write, done_q, done_rise;
  irq_state_t     state;
  logic [HCW-1:0] hold_cnt;

  // Only the low byte of a write carries data; the rest is deliberately ignored.
  logic unused_write_bits;
  assign unused_write_bits = ^bus_write_data[63:8];

  assign empty      = (count == '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign key_ready  = !full;
  assign push       = key_valid && !full;
  assign pop        = bus_read_enable && (bus_address == KEY_ADDR) && !empty;
  assign art_write  = bus_write_enable && (bus_address == ART_ADDR);
  assign stat_write = bus_write_enable && (bus_address == STAT_ADDR);
  assign done_rise  = interrupt_done && !done_q;

  always_comb begin
    bus_read_data = '0;
    if (bus_read_enable) begin
      if (bus_address == KEY_ADDR) begin
        if (!empty) bus_read_data[7:0] = mem[head];
      end else if (bus_address == STAT_ADDR) begin
        bus_read_data[9]   = overflow;
        bus_read_data[8]   = full;
        bus_read_data[7:4] = 4'(count);
        bus_read_data[0]   = empty;
      end
    end
  end

  // NOTE: the key storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= key_data;
  end

  // NOTE: every sequential block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A key dropped in the same cycle as a clear keeps the flag set.
      if (key_valid && full) overflow <= 1'b1;
      else if (stat_write)   overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_out   <= '0;
      char_valid <= 1'b0;
    end else begin
      char_valid <= art_write;
      if (art_write) char_out <= bus_write_data[7:0];
    end
  end

  // A pop and an acknowledge edge in the same cycle are a single holdoff event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      hold_cnt         <= '0;
      interrupt_vector <= 4'd0;
      done_q           <= 1'b0;
    end else begin
      done_q <= interrupt_done;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state            <= ST_PENDING;
            interrupt_vector <= 4'd1;
          end
        end
        ST_PENDING: begin
          if (pop || done_rise) begin
            state            <= ST_HOLDOFF;
            hold_cnt         <= '0;
            interrupt_vector <= 4'd0;
          end else if (empty) begin
            state            <= ST_IDLE;
            interrupt_vector <= 4'd0;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) state <= ST_IDLE;
          else                       hold_cnt <= hold_cnt + HCW'(1);
        end
        default: begin
          state            <= ST_IDLE;
          interrupt_vector <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_bus_responder.sv
// Directed bench for key_bus_responder: FIFO, status, character port,
// interrupt FSM and reset behaviour against hand-computed values.
module tb_key_bus_responder;

  localparam logic [63:0] KEY  = 64'h8000_0010;
  localparam logic [63:0] ART  = 64'h8000_0000;
  localparam logic [63:0] STAT = 64'h8000_0018;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_data = '0;
  logic        key_ready;
  logic [63:0] bus_address = '0;
  logic [63:0] bus_write_data = '0;
  logic        bus_write_enable = 1'b0;
  logic        bus_read_enable = 1'b0;
  logic [63:0] bus_read_data;
  logic [3:0]  interrupt_vector;
  logic        interrupt_done = 1'b0;
  logic [7:0]  char_out;
  logic        char_valid;

  int errors = 0;
  int checks = 0;

  key_bus_responder dut (
    .clk              (clk),
    .reset            (reset),
    .key_valid        (key_valid),
    .key_data         (key_data),
    .key_ready        (key_ready),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data),
    .interrupt_vector (interrupt_vector),
    .interrupt_done   (interrupt_done),
    .char_out         (char_out),
    .char_valid       (char_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational read between edges; the strobe is dropped before the next edge.
  task automatic peek(input logic [63:0] addr, output logic [63:0] data);
    bus_address     = addr;
    bus_read_enable = 1'b1;
    #1;
    data            = bus_read_data;
    bus_read_enable = 1'b0;
    #1;
  endtask

  task automatic push_key(input logic [7:0] k);
    key_valid = 1'b1;
    key_data  = k;
    tick();
    key_valid = 1'b0;
  endtask

  // Read KEY across one edge, checking the value presented before the pop.
  task automatic pop_key(input string tag, input logic [63:0] expected);
    bus_address     = KEY;
    bus_read_enable = 1'b1;
    #1;
    check(tag, bus_read_data, expected);
    tick();
    bus_read_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [63:0] rd;
  int          pulses;

  initial begin
    // Reset state
    #2;
    check("rst_vector", 64'(interrupt_vector), 64'd0);
    check("rst_key_ready", 64'(key_ready), 64'd1);
    check("rst_char_valid", 64'(char_valid), 64'd0);
    peek(STAT, rd);
    check("rst_stat", rd, 64'h1);
    idle(2);
    reset = 1'b1;
    idle(1);

    // Single key: interrupt, pop, holdoff
    push_key(8'h41);
    peek(STAT, rd);
    check("t1_stat_count1", rd, 64'h10);
    check("t1_vec_not_yet", 64'(interrupt_vector), 64'd0);
    tick();
    check("t1_vec_pending", 64'(interrupt_vector), 64'd1);
    pop_key("t1_read_41", 64'h41);
    check("t1_vec_after_pop", 64'(interrupt_vector), 64'd0);
    peek(STAT, rd);
    check("t1_stat_empty", rd, 64'h1);
    tick();
    check("t1_vec_holdoff1", 64'(interrupt_vector), 64'd0);
    tick();
    check("t1_vec_holdoff2", 64'(interrupt_vector), 64'd0);
    idle(2);
    check("t1_vec_idle", 64'(interrupt_vector), 64'd0);

    // Two keys: re-arm after holdoff
    key_valid = 1'b1;
    key_data  = 8'h41;
    tick();
    key_data  = 8'h42;
    tick();
    key_valid = 1'b0;
    check("t2_vec_pending", 64'(interrupt_vector), 64'd1);
    pop_key("t2_read_41", 64'h41);
    check("t2_vec_holdoff", 64'(interrupt_vector), 64'd0);
    idle(2);
    check("t2_vec_holdoff_end", 64'(interrupt_vector), 64'd0);
    tick();
    check("t2_vec_rearmed", 64'(interrupt_vector), 64'd1);
    pop_key("t2_read_42", 64'h42);
    peek(STAT, rd);
    check("t2_stat_count0", rd, 64'h1);
    idle(4);

    // Fill, overflow, clear, drain
    key_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      key_data = 8'h10 + 8'(i);
      tick();
      if (i == 6) check("t3_ready_at7", 64'(key_ready), 64'd1);
      if (i == 7) check("t3_ready_at8", 64'(key_ready), 64'd0);
    end
    key_valid = 1'b0;
    peek(STAT, rd);
    check("t3_stat_overflow", rd, 64'h380);
    bus_address      = STAT;
    bus_write_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0;
    peek(STAT, rd);
    check("t3_stat_cleared", rd, 64'h180);
    for (int i = 0; i < 8; i++) pop_key("t3_drain", 64'h10 + 64'(i));
    peek(STAT, rd);
    check("t3_stat_drained", rd, 64'h1);
    idle(4);
    check("t3_vec_idle", 64'(interrupt_vector), 64'd0);

    // Character output
    bus_address      = ART;
    bus_write_data   = 64'h5A;
    bus_write_enable = 1'b1;
    tick();
    bus_write_enable = 1'b0;
    check("t4_char_out", 64'(char_out), 64'h5A);
    check("t4_char_valid", 64'(char_valid), 64'd1);
    tick();
    check("t4_char_valid_drop", 64'(char_valid), 64'd0);
    check("t4_char_hold", 64'(char_out), 64'h5A);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      bus_write_enable = (i < 3);
      bus_write_data   = 64'h61 + 64'(i);
      tick();
      if (char_valid) pulses++;
    end
    bus_write_enable = 1'b0;
    check("t4_pulse_count", 64'(pulses), 64'd3);
    check("t4_char_last", 64'(char_out), 64'h63);

    // Empty read, simultaneous push and pop
    pop_key("t5_empty_read", 64'h0);
    peek(STAT, rd);
    check("t5_stat_empty", rd, 64'h1);
    push_key(8'h77);
    key_valid = 1'b1;
    key_data  = 8'h88;
    pop_key("t5_read_77", 64'h77);
    key_valid = 1'b0;
    peek(STAT, rd);
    check("t5_stat_count1", rd, 64'h10);
    pop_key("t5_read_88", 64'h88);
    idle(4);

    // Interrupt acknowledge edge
    push_key(8'h55);
    tick();
    check("t6_vec_pending", 64'(interrupt_vector), 64'd1);
    interrupt_done = 1'b1;
    tick();
    check("t6_vec_done", 64'(interrupt_vector), 64'd0);
    idle(3);
    check("t6_vec_rearm", 64'(interrupt_vector), 64'd1);
    idle(2);
    check("t6_level_no_event", 64'(interrupt_vector), 64'd1);
    interrupt_done = 1'b0;
    tick();
    interrupt_done = 1'b1;
    tick();
    check("t6_vec_second_edge", 64'(interrupt_vector), 64'd0);
    interrupt_done = 1'b0;
    pop_key("t6_read_55", 64'h55);
    idle(4);

    // Reset with keys buffered
    push_key(8'hA1);
    push_key(8'hA2);
    push_key(8'hA3);
    check("t7_vec_before_reset", 64'(interrupt_vector), 64'd1);
    reset = 1'b0;
    #1;
    check("t7_vec_reset", 64'(interrupt_vector), 64'd0);
    check("t7_ready_reset", 64'(key_ready), 64'd1);
    peek(STAT, rd);
    check("t7_stat_reset", rd, 64'h1);
    tick();
    reset = 1'b1;
    push_key(8'h99);
    peek(STAT, rd);
    check("t7_stat_after", rd, 64'h10);
    pop_key("t7_read_99", 64'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
